// File: rtl/pkt_framer.sv
// pkt_framer: frames marker-delimited bytes from an upstream FIFO into
// packets. Each packet is its payload bytes followed by an 8-bit additive
// checksum beat. Packets longer than MAX_LEN are cut and flagged with out_err.
module pkt_framer #(
    parameter int BITSIZE = 9,
    parameter int MAX_LEN = 256
) (
    input  logic               clk,
    input  logic               rstp,
    input  logic [BITSIZE-1:0] fifo_data,
    input  logic               fifo_emptyp,
    output logic               fifo_readp,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic               out_err,
    output logic [15:0]        pkt_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_CSUM = 2'd2;

    localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);

    logic [1:0]  state_q, state_d;
    logic [8:0]  len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic        out_err_q, out_err_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    logic        slot_free;
    logic        pop;
    logic        marker;
    logic [7:0]  byte_in;
    logic [8:0]  len_inc;

    assign slot_free = !out_valid_q || out_ready;
    assign marker    = fifo_data[BITSIZE-1];
    assign byte_in   = fifo_data[7:0];
    assign len_inc   = len_q + 9'd1;

    // NOTE: pop is gated by rstp because the reset state (IDLE, slot free)
    // would otherwise request a pop while the block is still held in reset.
    assign pop = !rstp && !fifo_emptyp && slot_free &&
                 (state_q == ST_IDLE || state_q == ST_DATA);

    assign fifo_readp = pop;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_err   = out_err_q;
    assign pkt_cnt   = pkt_cnt_q;

    // Next-state: framing FSM, running length/checksum and the output slot.
    always_comb begin
        // NOTE: every target gets a hold/default value up front so no path
        // through the case leaves a signal unassigned (no latches).
        state_d     = state_q;
        len_d       = len_q;
        csum_d      = csum_q;
        trunc_d     = trunc_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_err_d   = out_err_q;
        pkt_cnt_d   = pkt_cnt_q;
        out_valid_d = slot_free ? 1'b0 : out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    out_data_d  = byte_in;
                    out_sop_d   = 1'b1;
                    out_eop_d   = 1'b0;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    len_d       = 9'd1;
                    csum_d      = byte_in;
                    if (marker) begin
                        state_d = ST_CSUM;
                        trunc_d = 1'b0;
                    end else if (MAX_LEN_L == 9'd1) begin
                        state_d = ST_CSUM;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pop) begin
                    out_data_d  = byte_in;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b0;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    len_d       = len_inc;
                    csum_d      = csum_q + byte_in;
                    if (marker) begin
                        state_d = ST_CSUM;
                    end else if (len_inc == MAX_LEN_L) begin
                        // Forced cut: the next words start a fresh packet.
                        state_d = ST_CSUM;
                        trunc_d = 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                if (slot_free) begin
                    out_data_d  = csum_q;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b1;
                    out_err_d   = trunc_q;
                    out_valid_d = 1'b1;
                    pkt_cnt_d   = pkt_cnt_q + 16'd1;
                    trunc_d     = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight and drops a held beat.
    always_ff @(posedge clk or posedge rstp) begin
        // NOTE: registers update with non-blocking assignments so every
        // flop samples the pre-edge values computed above.
        if (rstp) begin
            state_q     <= ST_IDLE;
            len_q       <= 9'd0;
            csum_q      <= 8'd0;
            trunc_q     <= 1'b0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            pkt_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            trunc_q     <= trunc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Testbench for pkt_framer: two instances (MAX_LEN=256 and MAX_LEN=4) see the
// same word stream; accepted beats are compared against a packet-level model.
module tb_pkt_framer;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       err;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstp;
    logic        out_ready;

    logic [8:0]  fifo_data0, fifo_data4;
    logic        fifo_emptyp0, fifo_emptyp4;
    logic        fifo_readp0, fifo_readp4;
    logic [7:0]  out_data0, out_data4;
    logic        out_valid0, out_valid4;
    logic        out_sop0, out_sop4;
    logic        out_eop0, out_eop4;
    logic        out_err0, out_err4;
    logic [15:0] pkt_cnt0, pkt_cnt4;

    logic [8:0]  q0[$];
    logic [8:0]  q4[$];
    logic [8:0]  sent[$];
    beat_t       obs0[$];
    beat_t       obs4[$];
    int          obs_cyc0[$];
    beat_t       exp_q[$];
    int          exp_npk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          gap_en = 0;
    logic        last_pop;
    logic        stall0, stall4;
    beat_t       held0, held4;

    always #5 clk = ~clk;

    pkt_framer #(.BITSIZE(9), .MAX_LEN(256)) dut0 (
        .clk(clk), .rstp(rstp),
        .fifo_data(fifo_data0), .fifo_emptyp(fifo_emptyp0), .fifo_readp(fifo_readp0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sop(out_sop0), .out_eop(out_eop0), .out_err(out_err0), .pkt_cnt(pkt_cnt0)
    );

    pkt_framer #(.BITSIZE(9), .MAX_LEN(4)) dut4 (
        .clk(clk), .rstp(rstp),
        .fifo_data(fifo_data4), .fifo_emptyp(fifo_emptyp4), .fifo_readp(fifo_readp4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_sop(out_sop4), .out_eop(out_eop4), .out_err(out_err4), .pkt_cnt(pkt_cnt4)
    );

    // Packet-level reference: split the word stream into packets and append checksums.
    function automatic void model(input int max_len);
        int         len;
        logic [7:0] sum;
        logic [8:0] w;
        exp_q.delete();
        exp_npk = 0;
        len = 0;
        sum = 8'd0;
        foreach (sent[i]) begin
            w = sent[i];
            if (len == 0) sum = w[7:0];
            else          sum = sum + w[7:0];
            exp_q.push_back(beat_t'({(len == 0), 1'b0, 1'b0, w[7:0]}));
            len++;
            if (w[8] || len == max_len) begin
                exp_q.push_back(beat_t'({1'b0, 1'b1, !w[8], sum}));
                exp_npk++;
                len = 0;
            end
        end
    endfunction

    task automatic push_word(input logic [8:0] w);
        q0.push_back(w);
        q4.push_back(w);
        sent.push_back(w);
    endtask

    // One clock: drive inputs after the falling edge, sample, log, pop the model FIFOs.
    task automatic cycle();
        beat_t b0, b4;
        @(negedge clk);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_emptyp0 = (q0.size() == 0) || (gap_en != 0 && $urandom_range(0, 3) == 0);
        fifo_data0   = (q0.size() != 0) ? q0[0] : 9'h0;
        fifo_emptyp4 = (q4.size() == 0) || (gap_en != 0 && $urandom_range(0, 3) == 0);
        fifo_data4   = (q4.size() != 0) ? q4[0] : 9'h0;
        #1;
        cyc++;
        b0 = beat_t'({out_sop0, out_eop0, out_err0, out_data0});
        b4 = beat_t'({out_sop4, out_eop4, out_err4, out_data4});
        if (stall0) begin
            checks++;
            if (out_valid0 !== 1'b1 || b0 !== held0) begin
                errors++;
                $display("FAIL hold0 cyc %0d: got valid=%b beat=%h, expected valid=1 beat=%h", cyc, out_valid0, b0, held0);
            end
        end
        if (stall4) begin
            checks++;
            if (out_valid4 !== 1'b1 || b4 !== held4) begin
                errors++;
                $display("FAIL hold4 cyc %0d: got valid=%b beat=%h, expected valid=1 beat=%h", cyc, out_valid4, b4, held4);
            end
        end
        if (fifo_emptyp0) begin
            checks++;
            if (fifo_readp0 !== 1'b0) begin
                errors++;
                $display("FAIL readp_empty0 cyc %0d: got %b expected 0", cyc, fifo_readp0);
            end
        end
        if (fifo_emptyp4) begin
            checks++;
            if (fifo_readp4 !== 1'b0) begin
                errors++;
                $display("FAIL readp_empty4 cyc %0d: got %b expected 0", cyc, fifo_readp4);
            end
        end
        if (out_valid0 && !out_ready) begin
            checks++;
            if (fifo_readp0 !== 1'b0) begin
                errors++;
                $display("FAIL readp_busy0 cyc %0d: got %b expected 0", cyc, fifo_readp0);
            end
        end
        if (out_valid4 && !out_ready) begin
            checks++;
            if (fifo_readp4 !== 1'b0) begin
                errors++;
                $display("FAIL readp_busy4 cyc %0d: got %b expected 0", cyc, fifo_readp4);
            end
        end
        if (out_valid0 && out_ready) begin
            obs0.push_back(b0);
            obs_cyc0.push_back(cyc);
        end
        if (out_valid4 && out_ready) obs4.push_back(b4);
        stall0 = out_valid0 && !out_ready;
        stall4 = out_valid4 && !out_ready;
        held0 = b0;
        held4 = b4;
        last_pop = fifo_readp0 || fifo_readp4;
        if (fifo_readp0 && q0.size() != 0) void'(q0.pop_front());
        if (fifo_readp4 && q4.size() != 0) void'(q4.pop_front());
    endtask

    task automatic clear_model();
        q0.delete(); q4.delete(); sent.delete();
        obs0.delete(); obs4.delete(); obs_cyc0.delete();
        stall0 = 1'b0; stall4 = 1'b0; last_pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstp = 1'b1;
        clear_model();
        fifo_emptyp0 = 1'b1; fifo_emptyp4 = 1'b1;
        repeat (2) @(negedge clk);
        rstp = 1'b0;
    endtask

    // Run until both FIFOs are drained and both output slots are empty.
    task automatic drain(input string name);
        int n = 0;
        last_pop = 1'b0;
        while (n < 3000 && (q0.size() != 0 || q4.size() != 0 || out_valid0 || out_valid4 || last_pop)) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles without draining, expected < 3000", name, n);
        end
    endtask

    // Scoreboard: compare accepted beats and pkt_cnt of one instance with the model.
    task automatic scoreboard_compare(input string name, input int which);
        beat_t       got[$];
        logic [15:0] cnt;
        int          n;
        model(which == 0 ? 256 : 4);
        if (which == 0) begin got = obs0; cnt = pkt_cnt0; end
        else            begin got = obs4; cnt = pkt_cnt4; end
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_m%0d_beats: got %0d beats expected %0d", name, which, got.size(), exp_q.size());
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_m%0d_beat%0d: got sop/eop/err/data=%h expected %h", name, which, i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (cnt !== 16'(exp_npk)) begin
            errors++;
            $display("FAIL %s_m%0d_pkt_cnt: got %0d expected %0d", name, which, cnt, exp_npk);
        end
    endtask

    task automatic test_reset();
        rstp = 1'b1;
        @(negedge clk);
        fifo_emptyp0 = 1'b0; fifo_data0 = 9'h155;
        fifo_emptyp4 = 1'b0; fifo_data4 = 9'h155;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid0, out_data0, out_sop0, out_eop0, out_err0, pkt_cnt0, fifo_readp0} !== 29'd0) begin
            errors++;
            $display("FAIL reset0: got valid=%b data=%h sop=%b eop=%b err=%b cnt=%0d readp=%b expected all 0",
                     out_valid0, out_data0, out_sop0, out_eop0, out_err0, pkt_cnt0, fifo_readp0);
        end
        checks++;
        if ({out_valid4, out_data4, out_sop4, out_eop4, out_err4, pkt_cnt4, fifo_readp4} !== 29'd0) begin
            errors++;
            $display("FAIL reset4: got valid=%b data=%h sop=%b eop=%b err=%b cnt=%0d readp=%b expected all 0",
                     out_valid4, out_data4, out_sop4, out_eop4, out_err4, pkt_cnt4, fifo_readp4);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int  t0;
        logic ok;
        do_reset();
        ready_mode = 0; gap_en = 0;
        t0 = cyc;
        push_word(9'h011); push_word(9'h022); push_word(9'h133);
        drain("basic");
        scoreboard_compare("basic", 0);
        scoreboard_compare("basic", 1);
        ok = (obs_cyc0.size() == 4);
        for (int i = 0; i < obs_cyc0.size(); i++)
            if (obs_cyc0[i] != t0 + 2 + i) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timing: got %0d beats starting cycle %0d, expected 4 consecutive from %0d",
                     obs_cyc0.size(), (obs_cyc0.size() != 0) ? obs_cyc0[0] : -1, t0 + 2);
        end
        checks++;
        if (obs0.size() != 4 || obs0[3] !== beat_t'({1'b0, 1'b1, 1'b0, 8'h66})) begin
            errors++;
            $display("FAIL basic_csum: got %0d beats last=%h expected last=%h", obs0.size(),
                     (obs0.size() != 0) ? obs0[obs0.size()-1] : beat_t'(0), beat_t'({1'b0, 1'b1, 1'b0, 8'h66}));
        end
    endtask

    task automatic test_single();
        do_reset();
        ready_mode = 0; gap_en = 0;
        push_word(9'h1FF); push_word(9'h100);
        drain("single");
        scoreboard_compare("single", 0);
        scoreboard_compare("single", 1);
        checks++;
        if (pkt_cnt0 !== 16'd2) begin
            errors++;
            $display("FAIL single_cnt: got %0d expected 2", pkt_cnt0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ready_mode = 0; gap_en = 0;
        push_word(9'h0FF); push_word(9'h002); push_word(9'h103);
        drain("wrap");
        scoreboard_compare("wrap", 0);
        checks++;
        if (obs0.size() != 4 || obs0[3].data !== 8'h04) begin
            errors++;
            $display("FAIL wrap_csum: got %0d beats last data=%h expected 04", obs0.size(),
                     (obs0.size() != 0) ? obs0[obs0.size()-1].data : 8'hxx);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_mode = 1; gap_en = 0; out_ready = 1'b0;
        push_word(9'h0A1); push_word(9'h0B2); push_word(9'h1C3);
        drain("bp");
        scoreboard_compare("bp", 0);
        scoreboard_compare("bp", 1);
    endtask

    task automatic test_truncate();
        do_reset();
        ready_mode = 0; gap_en = 0;
        repeat (6) push_word(9'h001);
        drain("trunc");
        scoreboard_compare("trunc", 0);
        scoreboard_compare("trunc", 1);
        checks++;
        if (obs4.size() != 7 || obs4[4] !== beat_t'({1'b0, 1'b1, 1'b1, 8'h04}) || obs4[5].sop !== 1'b1) begin
            errors++;
            $display("FAIL trunc_cut: got %0d beats expected 7 with eop/err beat 04 then sop", obs4.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_mode = 0; gap_en = 0;
        push_word(9'h0AA); push_word(9'h0BB); push_word(9'h1CC);
        repeat (3) cycle();
        #2 rstp = 1'b1;
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || pkt_cnt0 !== 16'd0 || out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got valid0=%b cnt0=%0d valid4=%b expected 0 0 0", out_valid0, pkt_cnt0, out_valid4);
        end
        clear_model();
        fifo_emptyp0 = 1'b1; fifo_emptyp4 = 1'b1;
        @(negedge clk);
        rstp = 1'b0;
        push_word(9'h155);
        drain("midreset");
        scoreboard_compare("midreset", 0);
        checks++;
        if (obs0.size() == 0 || obs0[0].sop !== 1'b1) begin
            errors++;
            $display("FAIL midreset_sop: got %0d beats first sop=%b expected sop=1", obs0.size(),
                     (obs0.size() != 0) ? obs0[0].sop : 1'bx);
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            ready_mode = 2; gap_en = 1;
            for (int p = 0; p < 20; p++) begin
                len = $urandom_range(1, 12);
                for (int b = 0; b < len; b++)
                    push_word({(b == len - 1), 8'($urandom_range(0, 255))});
            end
            drain("random");
            scoreboard_compare("random", 0);
            scoreboard_compare("random", 1);
        end
        gap_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstp = 1'b1;
        out_ready = 1'b1;
        fifo_emptyp0 = 1'b1; fifo_emptyp4 = 1'b1;
        fifo_data0 = 9'h0; fifo_data4 = 9'h0;
        stall0 = 1'b0; stall4 = 1'b0; last_pop = 1'b0;
        held0 = '0; held4 = '0;
        test_reset();
        test_basic();
        test_single();
        test_wrap();
        test_backpressure();
        test_truncate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 Parameter: BITSIZE, 9, upstream word width; bit BITSIZE-1 is the last-byte marker, bits 7:0 are payload.
REQ-002 Parameter: MAX_LEN, 256, maximum payload bytes per packet before forced termination.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rstp  input  1  reset, asynchronous and active-high.
REQ-005 Port: fifo_data  input  BITSIZE  upstream FIFO head word; valid in the same cycle whenever fifo_emptyp=0.
REQ-006 Port: fifo_emptyp  input  1  upstream FIFO empty flag.
REQ-007 Port: fifo_readp  output  1  pop request to upstream FIFO; it pops on the next rising edge.
REQ-008 Port: out_data  output  8  framed output byte.
REQ-009 Port: out_valid  output  1  out_data/out_sop/out_eop/out_err hold a valid beat.
REQ-010 Port: out_ready  input  1  downstream accepts the beat when out_valid=1 and out_ready=1.
REQ-011 Port: out_sop  output  1  first payload byte of a packet.
REQ-012 Port: out_eop  output  1  checksum byte; last beat of a packet.
REQ-013 Port: out_err  output  1  truncation flag; meaningful only on the eop beat.
REQ-014 Port: pkt_cnt  output  16  count of completed packets, wraps modulo 2^16.

Function
REQ-015 All outputs SHALL be registered; out_data/out_sop/out_eop/out_err SHALL change only when the output slot is free (out_valid=0 or out_ready=1).
REQ-016 The slot is free when out_valid=0 or out_ready=1. A beat SHALL load only when the slot is free; a loaded beat SHALL set out_valid=1. If the slot is free and no beat loads, out_valid SHALL go 0.
REQ-017 fifo_readp SHALL be combinational: 1 iff state is IDLE or DATA, fifo_emptyp=0 and the slot is free; it SHALL never be 1 while fifo_emptyp=1.
REQ-018 The FSM SHALL have exactly three states: IDLE, DATA, CSUM.
REQ-019 IDLE, pop: load out_data=fifo_data[7:0], out_sop=1, out_eop=0, out_err=0; len=1; csum=fifo_data[7:0]. Next state: CSUM if the marker bit is 1 or MAX_LEN=1, else DATA.
REQ-020 DATA, pop: load out_data=fifo_data[7:0], out_sop=0, out_eop=0; len=len+1; csum=(csum+byte) mod 256. Next state: CSUM if the marker bit is 1 or the new len=MAX_LEN.
REQ-021 When len reaches MAX_LEN with marker bit 0, trunc SHALL be set. The following upstream words SHALL start a new packet; no words are discarded.
REQ-022 CSUM, slot free: load out_data=csum, out_sop=0, out_eop=1, out_err=trunc; pkt_cnt increments; trunc clears; next state is IDLE. No pop occurs in CSUM.
REQ-023 In IDLE/DATA with no pop (FIFO empty or slot busy), state, len and csum SHALL hold; out_* SHALL hold while out_valid=1 and out_ready=0.
REQ-024 Throughput: one beat per cycle with out_ready=1 and FIFO non-empty; packet of N bytes takes N+1 output beats. Latency from pop edge to out_valid=1 is 0 cycles (same edge).
REQ-025 len SHALL be 9 bits; csum SHALL be 8 bits and wrap modulo 256.

Reset
REQ-026 While rstp=1 (asynchronously): state=IDLE, out_valid=0, out_data=0, out_sop=0, out_eop=0, out_err=0, pkt_cnt=0, len=0, csum=0, trunc=0; fifo_readp=0.
REQ-027 Reset mid-packet SHALL abandon the packet with no eop beat and no pkt_cnt increment. A beat held but not accepted is dropped.

Verification
REQ-028 FIFO holds 0x011, 0x022, 0x133, out_ready=1 -> beats 11(sop), 22, 33, 66(eop, err=0) on 4 consecutive cycles; pkt_cnt=1.
REQ-029 Single word 0x1FF -> beats FF(sop), FF(eop); 0x100 -> 00(sop), 00(eop); pkt_cnt=2.
REQ-030 Stream of 0x0FF, 0x002, 0x103 -> checksum beat 0x04 (wrap of 0x104).
REQ-031 out_ready toggled 1/0 every cycle over a 3-byte packet -> no beat lost or duplicated; fifo_readp=0 in every cycle where out_valid=1 and out_ready=0.
REQ-032 With MAX_LEN=4, six 0x001 words and no marker -> packet 1: four 01 beats, then 04 with eop and err=1; remaining two words start packet 2 with sop.
REQ-033 rstp pulsed after 2 of 3 bytes accepted -> out_valid=0 immediately, pkt_cnt=0; the next word is framed with sop=1.
